// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the processor ports, the unified_mem_arbiter and the memory model.
// slave = arbiter side, master = processor/memory side (testbench drives it).
interface unified_mem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  // Handshake: a port raises *_req with stable addr/we/wdata and holds it until
  // its one-cycle *_ack; the ack cycle is the completion, rdata is valid from it on.
  logic              ma_i_if_req;
  logic [AWIDTH-1:0] ma_i_if_addr;
  logic              ma_o_if_ack;
  logic [DWIDTH-1:0] ma_o_if_rdata;

  logic              ma_i_dm_req;
  logic              ma_i_dm_we;
  logic [AWIDTH-1:0] ma_i_dm_addr;
  logic [DWIDTH-1:0] ma_i_dm_wdata;
  logic              ma_o_dm_ack;
  logic [DWIDTH-1:0] ma_o_dm_rdata;

  logic              ma_o_stall_if;
  logic              ma_o_stall_dm;
  logic              ma_o_busy;

  logic              ma_o_mem_en;
  logic              ma_o_mem_we;
  logic [AWIDTH-1:0] ma_o_mem_addr;
  logic [DWIDTH-1:0] ma_o_mem_wdata;
  logic [DWIDTH-1:0] ma_i_mem_rdata;

  modport slave (
    input  ma_i_if_req, ma_i_if_addr,
    output ma_o_if_ack, ma_o_if_rdata,
    input  ma_i_dm_req, ma_i_dm_we, ma_i_dm_addr, ma_i_dm_wdata,
    output ma_o_dm_ack, ma_o_dm_rdata,
    output ma_o_stall_if, ma_o_stall_dm, ma_o_busy,
    output ma_o_mem_en, ma_o_mem_we, ma_o_mem_addr, ma_o_mem_wdata,
    input  ma_i_mem_rdata
  );

  modport master (
    output ma_i_if_req, ma_i_if_addr,
    input  ma_o_if_ack, ma_o_if_rdata,
    output ma_i_dm_req, ma_i_dm_we, ma_i_dm_addr, ma_i_dm_wdata,
    input  ma_o_dm_ack, ma_o_dm_rdata,
    input  ma_o_stall_if, ma_o_stall_dm, ma_o_busy,
    input  ma_o_mem_en, ma_o_mem_we, ma_o_mem_addr, ma_o_mem_wdata,
    output ma_i_mem_rdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data ports onto one fixed-latency single-port memory (data wins ties).
// Optional macro FETCH_STARVE_GUARD_EN: after STARVE_LIMIT data grants while fetch waits, fetch wins.
module unified_mem_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     ma_clk,
  input  logic                     ma_rst,
  unified_mem_arbiter_if.slave     bus,
  output logic [1:0]               ma_o_dbg_state
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("MEM_LATENCY must be at least 1");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  state_t            r_state;
  owner_t            r_owner;
  logic [CW-1:0]     r_cnt;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic [DWIDTH-1:0] r_if_rdata;
  logic [DWIDTH-1:0] r_dm_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_wdata;

  logic              w_any_req;
  logic              w_grant_dm;

  assign w_any_req = bus.ma_i_if_req | bus.ma_i_dm_req;

`ifdef FETCH_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve_cnt;

  // Once the data port has been granted STARVE_LIMIT times over a waiting fetch, yield once.
  assign w_grant_dm = bus.ma_i_dm_req &
                      ~(bus.ma_i_if_req && (r_starve_cnt == SW'(STARVE_LIMIT)));

  always_ff @(posedge ma_clk) begin
    if (!ma_rst) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE && w_any_req) begin
      if (w_grant_dm && bus.ma_i_if_req) r_starve_cnt <= r_starve_cnt + 1'b1;
      else                               r_starve_cnt <= '0;
    end
  end
`else
  assign w_grant_dm = bus.ma_i_dm_req;
`endif

  always_ff @(posedge ma_clk) begin
    if (!ma_rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_cnt       <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      r_mem_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_mem_en <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_ACCESS;
            if (w_grant_dm) begin
              r_owner     <= OWN_DM;
              r_mem_we    <= bus.ma_i_dm_we;
              r_mem_addr  <= bus.ma_i_dm_addr;
              r_mem_wdata <= bus.ma_i_dm_wdata;
            end else begin
              r_owner     <= OWN_IF;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= bus.ma_i_if_addr;
              r_mem_wdata <= '0;
            end
          end
        end
        S_ACCESS: begin
          // The counter parks at MEM_LATENCY for the capture edge instead of wrapping.
          if (r_cnt == CW'(MEM_LATENCY)) begin
            r_state <= S_RESP;
            if (r_owner == OWN_IF) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= bus.ma_i_mem_rdata;
            end else begin
              r_dm_ack <= 1'b1;
              if (!r_mem_we) r_dm_rdata <= bus.ma_i_mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_owner <= OWN_NONE;
        end
        default: begin
          r_state <= S_IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign bus.ma_o_if_ack    = r_if_ack;
  assign bus.ma_o_if_rdata  = r_if_rdata;
  assign bus.ma_o_dm_ack    = r_dm_ack;
  assign bus.ma_o_dm_rdata  = r_dm_rdata;
  assign bus.ma_o_stall_if  = bus.ma_i_if_req & ~r_if_ack;
  assign bus.ma_o_stall_dm  = bus.ma_i_dm_req & ~r_dm_ack;
  assign bus.ma_o_busy      = (r_state != S_IDLE);
  assign bus.ma_o_mem_en    = r_mem_en;
  assign bus.ma_o_mem_we    = r_mem_we;
  assign bus.ma_o_mem_addr  = r_mem_addr;
  assign bus.ma_o_mem_wdata = r_mem_wdata;
  assign ma_o_dbg_state     = r_state;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed timing scenarios, then random traffic
// compared against a transaction-level model of grant order, ack timing and memory contents.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int SL = 2;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  unified_mem_arbiter #(
    .AWIDTH(AW), .DWIDTH(DW), .MEM_LATENCY(L), .STARVE_LIMIT(SL)
  ) dut (
    .ma_clk        (clk),
    .ma_rst        (rst_n),
    .bus           (bus),
    .ma_o_dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  function automatic logic [DW-1:0] def_word(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    if (a == 8'h40) return 32'hCAFE0040;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  logic [DW-1:0] ram [0:255];
  logic [255:0]  ram_written = '0;
  logic [7:0]    ram_rd_idx  = '0;

  always @(posedge clk) begin
    if (bus.ma_o_mem_en) begin
      ram_rd_idx <= bus.ma_o_mem_addr[7:0];
      if (bus.ma_o_mem_we) begin
        ram[bus.ma_o_mem_addr[7:0]]         <= bus.ma_o_mem_wdata;
        ram_written[bus.ma_o_mem_addr[7:0]] <= 1'b1;
      end
    end
  end
  assign bus.ma_i_mem_rdata = ram_written[ram_rd_idx] ? ram[ram_rd_idx] : def_word(ram_rd_idx);

  // ---------------- reference memory image ----------------
  logic [DW-1:0] ref_mem [0:255];
  logic [255:0]  ref_wr = '0;

  function automatic logic [DW-1:0] ref_read(input logic [7:0] a);
    return ref_wr[a] ? ref_mem[a] : def_word(a);
  endfunction

  task automatic ref_write(input logic [7:0] a, input logic [DW-1:0] d);
    ref_mem[a] = d;
    ref_wr[a]  = 1'b1;
  endtask

  // ---------------- scoreboard counters ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ma_i_if_req   = 1'b0;
    bus.ma_i_if_addr  = '0;
    bus.ma_i_dm_req   = 1'b0;
    bus.ma_i_dm_we    = 1'b0;
    bus.ma_i_dm_addr  = '0;
    bus.ma_i_dm_wdata = '0;
  endtask

  // ---------------- random-phase model state ----------------
  int            grant_c, next_idle, if_ack_c, dm_ack_c, sc, n_if_acks, n_dm_acks;
  bit            if_act, dm_act, pick_dm, pend_dm_load;
  logic [7:0]    if_a, dm_a;
  logic          dm_w;
  logic [DW-1:0] dm_d, pend_if_data, pend_dm_data, exp_if_rd, exp_dm_rd, prev_dm;

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (3) tick();

    // ---- reset state ----
    check("rst_if_ack",   bus.ma_o_if_ack, 0);
    check("rst_dm_ack",   bus.ma_o_dm_ack, 0);
    check("rst_if_rdata", bus.ma_o_if_rdata, 0);
    check("rst_dm_rdata", bus.ma_o_dm_rdata, 0);
    check("rst_mem_en",   bus.ma_o_mem_en, 0);
    check("rst_mem_we",   bus.ma_o_mem_we, 0);
    check("rst_mem_addr", bus.ma_o_mem_addr, 0);
    check("rst_mem_wd",   bus.ma_o_mem_wdata, 0);
    check("rst_busy",     bus.ma_o_busy, 0);
    check("rst_state",    dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // ---- single fetch ----
    bus.ma_i_if_req  = 1'b1;
    bus.ma_i_if_addr = 32'h10;
    #1;
    check("sf_stall_t0", bus.ma_o_stall_if, 1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) bus.ma_i_if_req = 1'b0;
      #1;
      check("sf_mem_en", bus.ma_o_mem_en, (c == 1));
      if (c == 1) begin
        check("sf_mem_we",   bus.ma_o_mem_we, 0);
        check("sf_mem_addr", bus.ma_o_mem_addr, 32'h10);
      end
      check("sf_if_ack",   bus.ma_o_if_ack, (c == 4));
      check("sf_stall_if", bus.ma_o_stall_if, (c < 4));
      if (c >= 4) check("sf_if_rdata", bus.ma_o_if_rdata, 32'hDEADBEEF);
    end

    // ---- collision: data load wins, fetch follows ----
    bus.ma_i_if_req  = 1'b1;
    bus.ma_i_if_addr = 32'h44;
    bus.ma_i_dm_req  = 1'b1;
    bus.ma_i_dm_we   = 1'b0;
    bus.ma_i_dm_addr = 32'h40;
    #1;
    check("col_stall_dm_t0", bus.ma_o_stall_dm, 1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 5)  bus.ma_i_dm_req = 1'b0;
      if (c == 10) bus.ma_i_if_req = 1'b0;
      #1;
      check("col_mem_en",   bus.ma_o_mem_en, (c == 1 || c == 6));
      if (c == 1) check("col_dm_addr", bus.ma_o_mem_addr, 32'h40);
      if (c == 6) check("col_if_addr", bus.ma_o_mem_addr, 32'h44);
      check("col_dm_ack",   bus.ma_o_dm_ack, (c == 4));
      check("col_if_ack",   bus.ma_o_if_ack, (c == 9));
      check("col_stall_if", bus.ma_o_stall_if, (c < 9));
      check("col_stall_dm", bus.ma_o_stall_dm, (c < 4));
      if (c >= 4) check("col_dm_rdata", bus.ma_o_dm_rdata, ref_read(8'h40));
      if (c >= 9) check("col_if_rdata", bus.ma_o_if_rdata, ref_read(8'h44));
    end

    // ---- store: load data register must not change ----
    prev_dm           = ref_read(8'h40);
    bus.ma_i_dm_req   = 1'b1;
    bus.ma_i_dm_we    = 1'b1;
    bus.ma_i_dm_addr  = 32'h20;
    bus.ma_i_dm_wdata = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) drive_idle();
      #1;
      check("st_mem_en", bus.ma_o_mem_en, (c == 1));
      if (c == 1) begin
        check("st_mem_we",   bus.ma_o_mem_we, 1);
        check("st_mem_addr", bus.ma_o_mem_addr, 32'h20);
        check("st_mem_wd",   bus.ma_o_mem_wdata, 32'h12345678);
      end
      check("st_dm_ack",    bus.ma_o_dm_ack, (c == 4));
      check("st_dm_rdata",  bus.ma_o_dm_rdata, prev_dm);
    end
    ref_write(8'h20, 32'h12345678);

    // ---- throughput: fetch held continuously ----
    bus.ma_i_if_req  = 1'b1;
    bus.ma_i_if_addr = 32'h10;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 15) bus.ma_i_if_req = 1'b0;
      #1;
      check("tp_if_ack", bus.ma_o_if_ack, (c >= 4 && ((c - 4) % 5) == 0));
    end

    // ---- reset during ACCESS ----
    bus.ma_i_if_req  = 1'b1;
    bus.ma_i_if_addr = 32'h10;
    tick();                      // T1
    check("rm_busy_t1", bus.ma_o_busy, 1);
    tick();                      // T2
    rst_n = 1'b0;
    tick();                      // T3
    check("rm_busy",      bus.ma_o_busy, 0);
    check("rm_mem_en",    bus.ma_o_mem_en, 0);
    check("rm_if_rdata",  bus.ma_o_if_rdata, 0);
    check("rm_dm_rdata",  bus.ma_o_dm_rdata, 0);
    rst_n = 1'b1;
    bus.ma_i_if_req = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      tick();
      check("rm_no_ack", bus.ma_o_if_ack, 0);
    end

    // ---- starvation: both ports held for 12 transactions ----
    bus.ma_i_if_req  = 1'b1;
    bus.ma_i_if_addr = 32'h10;
    bus.ma_i_dm_req  = 1'b1;
    bus.ma_i_dm_we   = 1'b0;
    bus.ma_i_dm_addr = 32'h40;
    n_if_acks = 0;
    n_dm_acks = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus.ma_o_if_ack || bus.ma_o_dm_ack) begin
`ifdef FETCH_STARVE_GUARD_EN
        check("sv_order_if", bus.ma_o_if_ack, (((n_if_acks + n_dm_acks) % 3) == 2));
`else
        check("sv_order_if", bus.ma_o_if_ack, 0);
`endif
        if (bus.ma_o_if_ack) n_if_acks++;
        if (bus.ma_o_dm_ack) n_dm_acks++;
      end
    end
    check("sv_total_acks", n_if_acks + n_dm_acks, 12);
`ifdef FETCH_STARVE_GUARD_EN
    check("sv_if_acks", n_if_acks, 4);
`else
    check("sv_if_acks", n_if_acks, 0);
`endif
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- random traffic against the transaction-level model ----
    grant_c   = -100;
    next_idle = 0;
    if_ack_c  = -100;
    dm_ack_c  = -100;
    sc        = 0;
    if_act    = 1'b0;
    dm_act    = 1'b0;
    exp_if_rd = '0;
    exp_dm_rd = '0;
    pend_dm_load = 1'b0;
    if_a = '0; dm_a = '0; dm_w = 1'b0; dm_d = '0;
    pend_if_data = '0; pend_dm_data = '0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (if_ack_c == c - 1) if_act = 1'b0;
      if (dm_ack_c == c - 1) dm_act = 1'b0;
      if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1'b1;
        if_a   = 8'($urandom_range(0, 255));
      end
      if (!dm_act && $urandom_range(0, 2) == 0) begin
        dm_act = 1'b1;
        dm_a   = 8'($urandom_range(0, 255));
        dm_w   = 1'($urandom_range(0, 1));
        dm_d   = $urandom;
      end
      bus.ma_i_if_req   = if_act;
      bus.ma_i_if_addr  = {24'h0, if_a};
      bus.ma_i_dm_req   = dm_act;
      bus.ma_i_dm_we    = dm_w;
      bus.ma_i_dm_addr  = {24'h0, dm_a};
      bus.ma_i_dm_wdata = dm_d;
      #1;
      if (c == if_ack_c) exp_if_rd = pend_if_data;
      if (c == dm_ack_c && pend_dm_load) exp_dm_rd = pend_dm_data;
      check("rnd_if_ack",   bus.ma_o_if_ack, (c == if_ack_c));
      check("rnd_dm_ack",   bus.ma_o_dm_ack, (c == dm_ack_c));
      check("rnd_if_rdata", bus.ma_o_if_rdata, exp_if_rd);
      check("rnd_dm_rdata", bus.ma_o_dm_rdata, exp_dm_rd);
      check("rnd_busy",     bus.ma_o_busy, (c > grant_c && c <= grant_c + L + 2));
      check("rnd_mem_en",   bus.ma_o_mem_en, (c == grant_c + 1));
      check("rnd_stall_if", bus.ma_o_stall_if, (if_act && c != if_ack_c));
      check("rnd_stall_dm", bus.ma_o_stall_dm, (dm_act && c != dm_ack_c));
      // One transaction every L+3 cycles; data port first unless the starve guard fires.
      if (c >= next_idle && (if_act || dm_act)) begin
        pick_dm = dm_act;
`ifdef FETCH_STARVE_GUARD_EN
        if (if_act && dm_act && sc == SL) pick_dm = 1'b0;
        sc = (pick_dm && if_act) ? sc + 1 : 0;
`endif
        grant_c   = c;
        next_idle = c + L + 3;
        if (pick_dm) begin
          dm_ack_c     = c + L + 2;
          pend_dm_load = !dm_w;
          if (dm_w) ref_write(dm_a, dm_d);
          else      pend_dm_data = ref_read(dm_a);
        end else begin
          if_ack_c     = c + L + 2;
          pend_if_data = ref_read(if_a);
        end
      end
    end
    drive_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port (driven by PC) and the data-memory port (MemRead/MemWrite from the MEM stage).
- Grants one transaction at a time, counts the fixed memory latency, and returns read data with a one-cycle acknowledge pulse.
- Produces stall signals that the datapath/controller use to freeze fetch or MEM while a port waits.
- Sits between the processor top and the memory model.

Parameters:
- AWIDTH, 32, address width of both ports and the memory.
- DWIDTH, 32, data width.
- MEM_LATENCY, 2, cycles from memory-enable cycle to valid read data; legal range ≥1.
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits; used only with the optional feature.

Ports:
- ma_clk  in  1  clock; all state updates on rising edge.
- ma_rst  in  1  reset; synchronous, active-low.
- ma_i_if_req  in  1  fetch request; held until ack.
- ma_i_if_addr  in  AWIDTH  fetch address.
- ma_o_if_ack  out  1  one-cycle pulse; fetch complete.
- ma_o_if_rdata  out  DWIDTH  fetched instruction; registered.
- ma_i_dm_req  in  1  data request; held until ack.
- ma_i_dm_we  in  1  1 = store, 0 = load.
- ma_i_dm_addr  in  AWIDTH  data address.
- ma_i_dm_wdata  in  DWIDTH  store data.
- ma_o_dm_ack  out  1  one-cycle pulse; data access complete.
- ma_o_dm_rdata  out  DWIDTH  load data; registered.
- ma_o_stall_if  out  1  if_req & ~if_ack (combinational).
- ma_o_stall_dm  out  1  dm_req & ~dm_ack (combinational).
- ma_o_busy  out  1  state != IDLE.
- ma_o_mem_en  out  1  memory enable; registered.
- ma_o_mem_we  out  1  memory write enable; registered.
- ma_o_mem_addr  out  AWIDTH  memory address; registered.
- ma_o_mem_wdata  out  DWIDTH  memory write data; registered.
- ma_i_mem_rdata  in  DWIDTH  memory read data.

Behaviour:
- Reset: when ma_rst==0 at a rising edge:
  - state=IDLE, latency counter=0, grant owner=none.
  - All outputs 0: acks, rdata registers, mem_en/we/addr/wdata, busy.
- FSM states IDLE, ACCESS, RESP.
- IDLE:
  - If any request is pending, select the owner: dm wins ties.
  - Latch owner, we, addr, wdata into mem_* registers.
  - mem_en=1 for the next cycle only; go to ACCESS with cnt=0.
  - If no request, stay in IDLE with mem_en=0.
  - Fetch requests always use mem_we=0, mem_wdata=0.
- ACCESS:
  - mem_en=0 after the first ACCESS cycle.
  - cnt increments each cycle.
  - At the edge where cnt==MEM_LATENCY, capture ma_i_mem_rdata into the owner's rdata register (loads/fetches only) and go to RESP.
  - Counter width is clog2(MEM_LATENCY+1); no wrap.
- RESP:
  - Owner's ack=1 for exactly this cycle; no new grant is made.
  - Next state IDLE.
  - Stores: dm_rdata keeps its previous value.
- Timing:
  - Request seen in IDLE at cycle T0.
  - mem_en at T1.
  - rdata sampled at T1+L.
  - ack at T2+L.
  - Back-to-back throughput: one transaction per L+3 cycles.
- rdata registers hold their value until that port's next read ack.
- Request dropped before ack: protocol violation. The transaction already granted still completes and acks; no abort.
- Request inputs are ignored outside IDLE; address/data changes after grant have no effect.
- Reset mid-ACCESS or mid-RESP: transaction abandoned, no ack issued, IDLE next cycle.
- Both ports requesting in IDLE: dm granted; fetch stays stalled (stall_if=1) until its own ack.

Optional Feature:
- Macro: FETCH_STARVE_GUARD_EN.
- Defined:
  - starve counter increments at each dm grant made while if_req=1.
  - Cleared on any fetch grant, on a dm grant while if_req=0, and on reset.
  - When the counter equals STARVE_LIMIT and both ports request, fetch is granted instead of dm.
- Undefined: strict dm priority; no counter logic present; fetch can starve indefinitely.

Test Plan:
- Single fetch, L=2: if_req=1, if_addr=0x10 at T0; memory drives 0xDEADBEEF at T3 -> mem_en=1, mem_we=0, mem_addr=0x10 only at T1; if_ack=1 at T4 only; if_rdata=0xDEADBEEF from T4; stall_if=1 at T0–T3, 0 at T4.
- Collision: if_req and dm_req (load, addr 0x40) both at T0 -> dm_ack at T4; fetch mem_en at T6; if_ack at T9; stall_if high T0–T8.
- Store: dm_we=1, addr 0x20, wdata 0x12345678 -> T1: mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x12345678; dm_ack at T4; dm_rdata unchanged from its prior value.
- Reset mid-op: fetch granted, ma_rst=0 during T2 -> T3: busy=0, mem_en=0; no if_ack ever; rdata registers=0.
- Starvation, STARVE_LIMIT=2, both requests held continuously:
  - Macro defined -> grant order dm, dm, if, dm, dm, if.
  - Macro undefined -> if_ack never asserts over 10 transactions.
- Throughput, L=2, if_req held continuously -> if_ack pulses every 5 cycles (T4, T9, T14).
